// File: rtl/axi_node_pkg.sv
// Shared types for the AXI node slave port: AW decoder state encoding and B response codes.
package axi_node_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HEAD,
    DRAIN,
    BRESP
  } aw_dec_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axi_aw_region_match.sv
// Region compare for every initiator port plus lowest-index priority; purely combinational.
// Region r of port i lives at flat index r*N_INIT_PORT+i of the start/end/enable vectors.
module axi_aw_region_match #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned N_INIT_PORT = 4,
  parameter int unsigned N_REGION    = 2
) (
  input  logic [ADDR_WIDTH-1:0]                      addr_i,
  input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] start_addr_i,
  input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] end_addr_i,
  input  logic [N_REGION*N_INIT_PORT-1:0]            enable_region_i,
  output logic [N_INIT_PORT-1:0]                     sel_o,
  output logic                                       miss_o
);

  logic [N_INIT_PORT-1:0] match;

  for (genvar i = 0; i < N_INIT_PORT; i++) begin : g_port
    logic [N_REGION-1:0] hit;
    for (genvar r = 0; r < N_REGION; r++) begin : g_reg
      localparam int unsigned IDX = r*N_INIT_PORT + i;
      assign hit[r] = enable_region_i[IDX]
                    & (addr_i >= start_addr_i[IDX*ADDR_WIDTH +: ADDR_WIDTH])
                    & (addr_i <= end_addr_i[IDX*ADDR_WIDTH +: ADDR_WIDTH]);
    end
    assign match[i] = |hit;
  end

  // Overlapping maps are legal; the lowest port index owns the address.
  always_comb begin
    logic found;
    found = 1'b0;
    sel_o = '0;
    for (int i = 0; i < N_INIT_PORT; i++) begin
      if (match[i] && !found) begin
        sel_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign miss_o = ~|match;

endmodule

// File: rtl/axi_aw_address_decoder.sv
// AW decode/route stage of the AXI node slave port; sequences the W error drain and DECERR B.
// Optional AXI_AW_DECERR_CNT_EN adds a saturating decode-error counter with synchronous clear.
module axi_aw_address_decoder
  import axi_node_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned ID_WIDTH    = 4,
  parameter int unsigned N_INIT_PORT = 4,
  parameter int unsigned N_REGION    = 2,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       awvalid_i,
  input  logic [ADDR_WIDTH-1:0]                      awaddr_i,
  input  logic [ID_WIDTH-1:0]                        awid_i,
  output logic                                       awready_o,
  output logic [N_INIT_PORT-1:0]                     awvalid_o,
  input  logic [N_INIT_PORT-1:0]                     awready_i,
  input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] start_addr_i,
  input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] end_addr_i,
  input  logic [N_REGION*N_INIT_PORT-1:0]            enable_region_i,
  output logic [N_INIT_PORT-1:0]                     DEST_o,
  output logic                                       push_DEST_o,
  input  logic                                       grant_FIFO_DEST_i,
  input  logic                                       wlast_pop_i,
  output logic                                       handle_error_o,
  input  logic                                       wdata_error_completed_i,
`ifdef AXI_AW_DECERR_CNT_EN
  input  logic                                       dec_err_clr_i,
  output logic [15:0]                                dec_err_cnt_o,
`endif
  output logic                                       bvalid_o,
  output logic [ID_WIDTH-1:0]                        bid_o,
  output logic [1:0]                                 bresp_o,
  input  logic                                       bready_i
);

  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH+1);

  aw_dec_state_e        state_q, state_d;
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic [OCC_W-1:0]     ahead_q, ahead_d;
  logic [ID_WIDTH-1:0]  bid_q, bid_d;
  logic [N_INIT_PORT-1:0] sel;
  logic                 miss;
  logic                 miss_hs;

  axi_aw_region_match #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .N_INIT_PORT (N_INIT_PORT),
    .N_REGION    (N_REGION)
  ) u_match (
    .addr_i          (awaddr_i),
    .start_addr_i    (start_addr_i),
    .end_addr_i      (end_addr_i),
    .enable_region_i (enable_region_i),
    .sel_o           (sel),
    .miss_o          (miss)
  );

  assign miss_hs = (state_q == IDLE) & miss & awvalid_i & grant_FIFO_DEST_i & ~rst;

  always_comb begin
    state_d        = state_q;
    ahead_d        = ahead_q;
    bid_d          = bid_q;
    awready_o      = 1'b0;
    awvalid_o      = '0;
    DEST_o         = '0;
    push_DEST_o    = 1'b0;
    handle_error_o = 1'b0;
    bvalid_o       = 1'b0;
    bresp_o        = OKAY;
    unique case (state_q)
      IDLE: begin
        if (!miss) begin
          awvalid_o = sel & {N_INIT_PORT{awvalid_i & grant_FIFO_DEST_i}};
          awready_o = |(awready_i & sel) & grant_FIFO_DEST_i;
          DEST_o    = sel;
        end else begin
          awready_o = grant_FIFO_DEST_i;
        end
        push_DEST_o = awvalid_i & awready_o;
        if (miss_hs) begin
          // Entries still queued ahead of the error entry, net of a pop this cycle.
          bid_d   = awid_i;
          ahead_d = occ_q - OCC_W'(wlast_pop_i);
          state_d = (ahead_d == '0) ? DRAIN : WAIT_HEAD;
        end
      end
      WAIT_HEAD: begin
        if (wlast_pop_i) ahead_d = ahead_q - OCC_W'(1);
        if (ahead_d == '0) state_d = DRAIN;
      end
      DRAIN: begin
        handle_error_o = 1'b1;
        if (wdata_error_completed_i) state_d = BRESP;
      end
      BRESP: begin
        bvalid_o = 1'b1;
        bresp_o  = DECERR;
        if (bready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs stay quiet while reset is held, since the state register only clears on the edge.
    if (rst) begin
      awready_o      = 1'b0;
      awvalid_o      = '0;
      DEST_o         = '0;
      push_DEST_o    = 1'b0;
      handle_error_o = 1'b0;
      bvalid_o       = 1'b0;
      bresp_o        = OKAY;
    end
    occ_d = occ_q + OCC_W'(push_DEST_o) - OCC_W'(wlast_pop_i);
  end

  assign bid_o = bid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      occ_q   <= '0;
      ahead_q <= '0;
      bid_q   <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      ahead_q <= ahead_d;
      bid_q   <= bid_d;
    end
  end

`ifdef AXI_AW_DECERR_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (dec_err_clr_i)                    cnt_d = '0;
    else if (miss_hs && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign dec_err_cnt_o = cnt_q;
`endif

  // The W router must never pop an entry that was not pushed.
  assert property (@(posedge clk) disable iff (rst) !(wlast_pop_i && occ_q == '0));

endmodule

// File: tb/tb_axi_aw_address_decoder.sv
// Directed bench for axi_aw_address_decoder: decode boundaries, routing, error drain, reset.
module tb_axi_aw_address_decoder;

  localparam int AW = 32;
  localparam int IW = 4;
  localparam int NP = 4;
  localparam int NR = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                awvalid_i;
  logic [AW-1:0]       awaddr_i;
  logic [IW-1:0]       awid_i;
  logic                awready_o;
  logic [NP-1:0]       awvalid_o;
  logic [NP-1:0]       awready_i;
  logic [NR*NP*AW-1:0] start_addr_i;
  logic [NR*NP*AW-1:0] end_addr_i;
  logic [NR*NP-1:0]    enable_region_i;
  logic [NP-1:0]       DEST_o;
  logic                push_DEST_o;
  logic                grant_FIFO_DEST_i;
  logic                wlast_pop_i;
  logic                handle_error_o;
  logic                wdata_error_completed_i;
  logic                bvalid_o;
  logic [IW-1:0]       bid_o;
  logic [1:0]          bresp_o;
  logic                bready_i;
`ifdef AXI_AW_DECERR_CNT_EN
  logic                dec_err_clr_i;
  logic [15:0]         dec_err_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  axi_aw_address_decoder dut (
    .clk                     (clk),
    .rst                     (rst),
    .awvalid_i               (awvalid_i),
    .awaddr_i                (awaddr_i),
    .awid_i                  (awid_i),
    .awready_o               (awready_o),
    .awvalid_o               (awvalid_o),
    .awready_i               (awready_i),
    .start_addr_i            (start_addr_i),
    .end_addr_i              (end_addr_i),
    .enable_region_i         (enable_region_i),
    .DEST_o                  (DEST_o),
    .push_DEST_o             (push_DEST_o),
    .grant_FIFO_DEST_i       (grant_FIFO_DEST_i),
    .wlast_pop_i             (wlast_pop_i),
    .handle_error_o          (handle_error_o),
    .wdata_error_completed_i (wdata_error_completed_i),
`ifdef AXI_AW_DECERR_CNT_EN
    .dec_err_clr_i           (dec_err_clr_i),
    .dec_err_cnt_o           (dec_err_cnt_o),
`endif
    .bvalid_o                (bvalid_o),
    .bid_o                   (bid_o),
    .bresp_o                 (bresp_o),
    .bready_i                (bready_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_region(input int r, input int p, input logic [AW-1:0] s,
                            input logic [AW-1:0] e, input logic en);
    start_addr_i[(r*NP+p)*AW +: AW] = s;
    end_addr_i[(r*NP+p)*AW +: AW]   = e;
    enable_region_i[r*NP+p]         = en;
  endtask

  // Full miss round trip starting with an empty DEST FIFO.
  task automatic do_miss(input logic [IW-1:0] id);
    awvalid_i = 1'b1; awaddr_i = 32'hF000_0000; awid_i = id;
    tick();
    awvalid_i = 1'b0;
    wdata_error_completed_i = 1'b1; wlast_pop_i = 1'b1;
    tick();
    wdata_error_completed_i = 1'b0; wlast_pop_i = 1'b0; bready_i = 1'b1;
    tick();
    bready_i = 1'b0;
  endtask

  logic [AW-1:0] dec_addr [10];
  logic [NP-1:0] dec_exp  [10];

  initial begin
    rst = 1'b1; awvalid_i = 1'b1; awaddr_i = 32'hF000_0000; awid_i = '0;
    awready_i = 4'hF; grant_FIFO_DEST_i = 1'b1; wlast_pop_i = 1'b0;
    wdata_error_completed_i = 1'b0; bready_i = 1'b0;
`ifdef AXI_AW_DECERR_CNT_EN
    dec_err_clr_i = 1'b0;
`endif
    start_addr_i = '0; end_addr_i = '0; enable_region_i = '0;
    set_region(0, 2, 32'h1000, 32'h1FFF, 1'b1);
    set_region(0, 1, 32'h2000, 32'h2FFF, 1'b1);
    set_region(1, 3, 32'h2000, 32'h3FFF, 1'b1);
    set_region(0, 0, 32'h4000, 32'h4FFF, 1'b1);
    set_region(1, 0, 32'h5000, 32'h5FFF, 1'b0);

    tick(); tick();
    chk("rst_awready", 32'(awready_o), 0);
    chk("rst_awvalid", 32'(awvalid_o), 0);
    chk("rst_push", 32'(push_DEST_o), 0);
    chk("rst_handle", 32'(handle_error_o), 0);
    chk("rst_bvalid", 32'(bvalid_o), 0);
    chk("rst_bresp", 32'(bresp_o), 0);
    chk("rst_bid", 32'(bid_o), 0);
    awvalid_i = 1'b0; rst = 1'b0;
    tick();

    // Decode boundaries, observed on DEST_o with no handshake.
    dec_addr = '{32'h1000, 32'h1FFF, 32'h0FFF, 32'h2000, 32'h2FFF,
                 32'h3000, 32'h3FFF, 32'h4000, 32'h5000, 32'hF000_0000};
    dec_exp  = '{4'b0100, 4'b0100, 4'b0000, 4'b0010, 4'b0010,
                 4'b1000, 4'b1000, 4'b0001, 4'b0000, 4'b0000};
    for (int k = 0; k < 10; k++) begin
      awaddr_i = dec_addr[k];
      #1;
      chk($sformatf("decode_%0h", dec_addr[k]), 32'(DEST_o), 32'(dec_exp[k]));
    end

    // Hit on port 2; ready withheld first, then granted.
    awvalid_i = 1'b1; awaddr_i = 32'h1800; awready_i = 4'b0000;
    #1;
    chk("hit2_noready_awvalid", 32'(awvalid_o), 32'b0100);
    chk("hit2_noready_awready", 32'(awready_o), 0);
    chk("hit2_noready_push", 32'(push_DEST_o), 0);
    awready_i = 4'b0100;
    #1;
    chk("hit2_awvalid", 32'(awvalid_o), 32'b0100);
    chk("hit2_awready", 32'(awready_o), 1);
    chk("hit2_push", 32'(push_DEST_o), 1);
    chk("hit2_dest", 32'(DEST_o), 32'b0100);
    tick();

    awaddr_i = 32'h2000; awready_i = 4'b0010;
    #1;
    chk("overlap_awvalid", 32'(awvalid_o), 32'b0010);
    chk("overlap_push", 32'(push_DEST_o), 1);
    chk("overlap_dest", 32'(DEST_o), 32'b0010);
    tick();

    // Miss behind two outstanding hits.
    awaddr_i = 32'hF000_0000; awid_i = 4'h5; awready_i = 4'hF;
    #1;
    chk("miss2_awready", 32'(awready_o), 1);
    chk("miss2_awvalid", 32'(awvalid_o), 0);
    chk("miss2_push", 32'(push_DEST_o), 1);
    chk("miss2_dest", 32'(DEST_o), 0);
    tick();
    awaddr_i = 32'h1800; awid_i = 4'h0;
    #1;
    chk("wait_awready", 32'(awready_o), 0);
    chk("wait_push", 32'(push_DEST_o), 0);
    chk("wait_handle0", 32'(handle_error_o), 0);
    wlast_pop_i = 1'b1; tick(); wlast_pop_i = 1'b0;
    #1;
    chk("wait_pop1_handle", 32'(handle_error_o), 0);
    chk("wait_pop1_awready", 32'(awready_o), 0);
    wlast_pop_i = 1'b1; tick(); wlast_pop_i = 1'b0;
    #1;
    chk("wait_pop2_handle", 32'(handle_error_o), 1);
    chk("drain_awready", 32'(awready_o), 0);
    chk("drain_awvalid", 32'(awvalid_o), 0);
    awvalid_i = 1'b0;
    wdata_error_completed_i = 1'b1; wlast_pop_i = 1'b1;
    tick();
    wdata_error_completed_i = 1'b0; wlast_pop_i = 1'b0;
    #1;
    chk("bresp_bvalid", 32'(bvalid_o), 1);
    chk("bresp_bid", 32'(bid_o), 5);
    chk("bresp_code", 32'(bresp_o), 3);
    chk("bresp_handle", 32'(handle_error_o), 0);
    tick();
    chk("bresp_hold", 32'(bvalid_o), 1);
    bready_i = 1'b1; tick(); bready_i = 1'b0;
    #1;
    chk("bresp_done_bvalid", 32'(bvalid_o), 0);
    chk("bresp_done_code", 32'(bresp_o), 0);
    awvalid_i = 1'b1; awaddr_i = 32'h1800; awready_i = 4'b0100;
    #1;
    chk("idle_restored_awready", 32'(awready_o), 1);
    awvalid_i = 1'b0;

    // Miss with an empty FIFO goes straight to draining.
    awvalid_i = 1'b1; awaddr_i = 32'hF000_0000; awid_i = 4'hA;
    #1;
    chk("miss0_push", 32'(push_DEST_o), 1);
    tick();
    awvalid_i = 1'b0;
    #1;
    chk("miss0_handle", 32'(handle_error_o), 1);
    wdata_error_completed_i = 1'b1; wlast_pop_i = 1'b1;
    tick();
    wdata_error_completed_i = 1'b0; wlast_pop_i = 1'b0;
    #1;
    chk("miss0_bvalid", 32'(bvalid_o), 1);
    chk("miss0_bid", 32'(bid_o), 32'hA);
    bready_i = 1'b1; tick(); bready_i = 1'b0;

    // FIFO full blocks both hits and misses.
    grant_FIFO_DEST_i = 1'b0; awvalid_i = 1'b1; awaddr_i = 32'h1800; awready_i = 4'b0100;
    #1;
    chk("full_hit_awready", 32'(awready_o), 0);
    chk("full_hit_awvalid", 32'(awvalid_o), 0);
    chk("full_hit_push", 32'(push_DEST_o), 0);
    awaddr_i = 32'hF000_0000;
    #1;
    chk("full_miss_awready", 32'(awready_o), 0);
    chk("full_miss_push", 32'(push_DEST_o), 0);
    tick();
    grant_FIFO_DEST_i = 1'b1; awaddr_i = 32'h1800;
    #1;
    chk("grant_hit_awready", 32'(awready_o), 1);
    chk("grant_hit_push", 32'(push_DEST_o), 1);
    tick();

    // Miss behind one hit, error entry left unpopped, then reset in BRESP.
    awaddr_i = 32'hF000_0000; awid_i = 4'h3;
    #1;
    chk("grant_miss_push", 32'(push_DEST_o), 1);
    tick();
    awvalid_i = 1'b0;
    wlast_pop_i = 1'b1; tick(); wlast_pop_i = 1'b0;
    #1;
    chk("miss1_handle", 32'(handle_error_o), 1);
    wdata_error_completed_i = 1'b1; tick(); wdata_error_completed_i = 1'b0;
    #1;
    chk("miss1_bvalid", 32'(bvalid_o), 1);
    chk("miss1_bid", 32'(bid_o), 3);
    rst = 1'b1; tick(); rst = 1'b0;
    #1;
    chk("rst_bresp_bvalid", 32'(bvalid_o), 0);
    chk("rst_bresp_bid", 32'(bid_o), 0);
    awvalid_i = 1'b1; awid_i = 4'h7;
    #1;
    chk("post_rst_awready", 32'(awready_o), 1);
    tick();
    awvalid_i = 1'b0;
    #1;
    chk("post_rst_occ0_drain", 32'(handle_error_o), 1);
    wdata_error_completed_i = 1'b1; wlast_pop_i = 1'b1;
    tick();
    wdata_error_completed_i = 1'b0; wlast_pop_i = 1'b0;
    #1;
    chk("post_rst_bid", 32'(bid_o), 7);
    bready_i = 1'b1; tick(); bready_i = 1'b0;

`ifdef AXI_AW_DECERR_CNT_EN
    #1;
    chk("cnt_one", 32'(dec_err_cnt_o), 1);
    do_miss(4'h1);
    do_miss(4'h2);
    #1;
    chk("cnt_three", 32'(dec_err_cnt_o), 3);
    dec_err_clr_i = 1'b1; tick(); dec_err_clr_i = 1'b0;
    #1;
    chk("cnt_clr", 32'(dec_err_cnt_o), 0);
`else
    do_miss(4'h1);
    #1;
    chk("final_idle_bvalid", 32'(bvalid_o), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
